shift_arb_ser: RTL
==================

Name: shift_arb_ser

Overview:
Two-requester round-robin arbiter and sequencer for a shared parallel-to-serial shift path. It accepts WIDTH-bit words from two independent valid/ready sources and grants one word at a time. It shifts each granted word out MSB-first, one bit per clk, with frame markers. It sits in front of the serial shift/delay chain so that several producers can share one serial lane.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32. The bit counter is clog2(WIDTH) bits wide.

Ports:
clk  input  1  clock; all state updates on the rising edge
rstn  input  1  synchronous active-low reset
req0_valid  input  1  requester 0 has a word
req0_data  input  WIDTH  requester 0 word
req0_ready  output  1  requester 0 word accepted this cycle when valid is also high
req1_valid  input  1  requester 1 has a word
req1_data  input  WIDTH  requester 1 word
req1_ready  output  1  requester 1 word accepted this cycle when valid is also high
ser_out  output  1  serial data bit (registered)
ser_valid  output  1  ser_out carries a valid bit (registered)
ser_first  output  1  current bit is the MSB of a frame (registered)
ser_last  output  1  current bit is the LSB of a frame (registered)
ser_src  output  1  index of the requester that owns the current frame (registered)
busy  output  1  a frame is in progress; equals ser_valid

Behaviour:
- Reset is rstn, synchronous, active-low; clock is clk. While rstn=0:
  - req0_ready and req1_ready are forced to 0 combinationally.
  - At the edge: state becomes IDLE, the shift register and bit counter clear, and the priority pointer becomes 0 (req0 favoured).
  - ser_out, ser_valid, ser_first, ser_last, ser_src and busy are all 0.
- Requester rule: once valid is asserted it must stay high, with data stable, until the cycle where valid and ready are both high. Ready may depend combinationally on both valids and on the state.
- Grant is combinational:
  - Both valid: the requester named by the pointer.
  - One valid: that requester.
  - Neither valid: no grant.
- Accept window: state IDLE, or state SHIFT with the counter at 0 (last bit on the output this cycle). Only the granted requester sees ready=1, and only inside the accept window.
- On accept at edge T:
  - The word is loaded into the shift register, the counter is set to WIDTH-1, ser_src is set to the granted index, and the pointer is set to the other index.
  - State becomes SHIFT.
- SHIFT state:
  - First cycle after T: ser_valid=1, ser_first=1, ser_out=word[WIDTH-1].
  - Each following edge shifts the register left by one and decrements the counter. ser_out follows word[WIDTH-2] down to word[0].
  - ser_last=1 exactly when the counter is 0. ser_first is high only in the first bit cycle.
  - The frame occupies exactly WIDTH consecutive cycles.
- Frame end: at the edge leaving counter 0:
  - If an accept happens in that cycle, the next frame starts immediately with no gap cycle.
  - Otherwise state returns to IDLE and ser_valid, ser_first and ser_last go to 0.
- Throughput: one word per WIDTH cycles under continuous demand.
- Latency: accept edge to first serial bit is 1 cycle.
- Fairness: with both requesters continuously valid, frames strictly alternate. No requester waits more than one frame.
- Pointer update: the pointer changes only on an accept; an idle cycle does not alter it.
- Reset mid-frame: the frame is aborted at that edge. No remaining bits are emitted and the partial frame is not resumed. After rstn returns high, req0 has priority.
- The counter never underflows; the decrement happens only while the counter is nonzero.
- ser_out is 0 whenever ser_valid=0.

Test Plan:
1. Hold rstn=0 for 3 cycles with both valids high -> both readies 0, ser_valid 0 throughout. In the first cycle with rstn=1, req0_ready=1 and req1_ready=0.
2. Send req0 word 0xA5 alone -> from the next cycle, ser_out = 1,0,1,0,0,1,0,1 over 8 cycles. ser_first only on cycle 1, ser_last only on cycle 8, ser_src=0. req0_ready=0 on bit cycles 1-7.
3. Hold req0=0xFF and req1=0x00 continuously valid -> frames alternate src 0,1,0,1. ser_valid stays high with no gaps; ser_out is 8 ones then 8 zeros, repeating.
4. After reset, assert only req1_valid with 0x3C -> req1 is granted immediately and ser_src=1. Then assert both together -> req0 wins the next grant.
5. Start a req0 frame with 0xF0 and pull rstn low on bit cycle 3 -> ser_valid=0 on the following cycle and no remaining bits are emitted. After release with both valid, req0 is granted first.
6. Feed req1 0x81 then 0x7E back-to-back, req0 idle -> 16 contiguous ser_valid cycles. ser_first on cycles 1 and 9, ser_last on cycles 8 and 16. Serial stream: 1000000101111110.

Source files
------------

// File: rtl/shift_arb_ser.sv
// Two-requester round-robin arbiter feeding a shared MSB-first serializer.
// A new word is accepted while idle or on the last bit of the current frame.
module shift_arb_ser #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_first,
  output logic             ser_last,
  output logic             ser_src,
  output logic             busy
);

  // state | meaning
  // IDLE  | no frame on the lane, accept window open
  // SHIFT | frame in progress, cnt = bits remaining after the current one
  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             ptr;
  logic             src_q;
  logic             first_q;
  logic             gnt;
  logic             window;
  logic             accept;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_comb begin
    gnt        = 1'b0;
    window     = 1'b0;
    accept     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    state_nxt  = state;
    if (req0_valid && req1_valid) gnt = ptr;
    else                          gnt = req1_valid;
    window = (state == IDLE) || ((state == SHIFT) && cnt_zero);
    accept = rstn && window && (req0_valid || req1_valid);
    req0_ready = accept && !gnt;
    req1_ready = accept && gnt;
    if (accept)                            state_nxt = SHIFT;
    else if ((state == SHIFT) && cnt_zero) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg   <= '0;
      cnt     <= '0;
      ptr     <= 1'b0;
      src_q   <= 1'b0;
      first_q <= 1'b0;
    end else if (accept) begin
      shreg   <= gnt ? req1_data : req0_data;
      cnt     <= CW'(WIDTH - 1);
      ptr     <= !gnt;
      src_q   <= gnt;
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      // Counter holds at zero; the frame simply ends.
      if ((state == SHIFT) && !cnt_zero) begin
        shreg <= {shreg[WIDTH-2:0], 1'b0};
        cnt   <= cnt - 1'b1;
      end
    end
  end

  assign ser_valid = (state == SHIFT);
  assign ser_out   = ser_valid && shreg[WIDTH-1];
  assign ser_first = first_q;
  assign ser_last  = ser_valid && cnt_zero;
  assign ser_src   = src_q;
  assign busy      = ser_valid;

endmodule
